// File: rtl/full_handshake_pkg.sv
// Definitions shared by both endpoints of the four-phase handshake link.
package full_handshake_pkg;

  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } hs_state_e;

endpackage

// File: rtl/full_handshake_rx_hs_sync.sv
// Multi-flop level synchroniser for a single control bit crossing into the local clock domain.
module hs_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the asynchronous level through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/full_handshake_rx.sv
// Receive endpoint of the four-phase handshake link: captures the transmitter's word,
// presents it on valid/ready and returns the acknowledge level.
module full_handshake_rx
  import full_handshake_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk_r,
  input  logic              rst_n_r,
  input  logic              req_in,
  input  logic [DATA_W-1:0] din,
  output logic              ack_out,
  output logic              dout_val,
  input  logic              dout_rdy,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  xfer_cnt
);

  logic              req_s;
  logic              take_s;
  hs_state_e         state_r;
  logic              dout_val_r;
  logic [DATA_W-1:0] dout_r;
  logic [CNT_W-1:0]  xfer_cnt_r;

  hs_sync #(
    .STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk  (clk_r),
    .rst_n(rst_n_r),
    .d    (req_in),
    .q    (req_s)
  );

  assign take_s = dout_val_r & dout_rdy;

  // Handshake FSM plus the single-word output register and accept counter.
  // The FSM looks at the pre-accept dout_val, so a word accepted this cycle
  // frees the buffer for a capture on the following cycle.
  always_ff @(posedge clk_r or negedge rst_n_r) begin
    if (!rst_n_r) begin
      state_r    <= IDLE;
      dout_val_r <= 1'b0;
      dout_r     <= {DATA_W{1'b0}};
      xfer_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (take_s) begin
        dout_val_r <= 1'b0;
        xfer_cnt_r <= xfer_cnt_r + CNT_W'(1);
      end
      case (state_r)
        IDLE: begin
          if (req_s && !dout_val_r) begin
            dout_r     <= din;
            dout_val_r <= 1'b1;
            state_r    <= ACK;
          end
        end
        ACK: begin
          if (!req_s) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign ack_out  = (state_r == ACK);
  assign dout_val = dout_val_r;
  assign dout     = dout_r;
  assign xfer_cnt = xfer_cnt_r;

endmodule

// File: tb/tb_full_handshake_rx.sv
// Directed and asynchronous-stimulus bench for full_handshake_rx with a word scoreboard.
`timescale 1ns/1ps
module tb_full_handshake_rx;

  logic        clk_r = 1'b0;
  logic        tclk  = 1'b0;
  logic        rst_n_r;
  logic        req_in;
  logic [31:0] din;
  logic        dout_rdy;
  logic        ack_out, dout_val;
  logic [31:0] dout;
  logic [15:0] xfer_cnt;
  logic        ack4, val4;
  logic [31:0] dout4;
  logic [3:0]  cnt4;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] sb[$];
  int          cnt_model = 0;
  logic [31:0] exp_w;
  logic [15:0] cnt_before;

  always #6 clk_r = ~clk_r;
  always #5 tclk  = ~tclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  full_handshake_rx #(.DATA_W(32), .SYNC_STAGES(2), .CNT_W(16)) dut (
    .clk_r(clk_r), .rst_n_r(rst_n_r), .req_in(req_in), .din(din),
    .ack_out(ack_out), .dout_val(dout_val), .dout_rdy(dout_rdy),
    .dout(dout), .xfer_cnt(xfer_cnt)
  );

  full_handshake_rx #(.DATA_W(32), .SYNC_STAGES(2), .CNT_W(4)) dut4 (
    .clk_r(clk_r), .rst_n_r(rst_n_r), .req_in(req_in), .din(din),
    .ack_out(ack4), .dout_val(val4), .dout_rdy(dout_rdy),
    .dout(dout4), .xfer_cnt(cnt4)
  );

  // Scoreboard monitor: checks reset state, counters and every accepted word.
  always @(negedge clk_r) begin
    if (!rst_n_r) begin
      chk("rst_ack", ack_out, 1'b0);
      chk("rst_val", dout_val, 1'b0);
      chk("rst_dout", dout, 32'h0);
      chk("rst_cnt", xfer_cnt, 16'h0);
      cnt_model = 0;
    end else begin
      chk("xfer_cnt", xfer_cnt, cnt_model[15:0]);
      chk("xfer_cnt4", cnt4, cnt_model[3:0]);
      if (dout_val && dout_rdy) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", dout_val, 1'b0);
        end else begin
          exp_w = sb.pop_front();
          chk("word", dout, exp_w);
        end
        cnt_model++;
      end
    end
  end

  task automatic wait_ack(input logic lvl);
    int n = 0;
    while (ack_out !== lvl && n < 3000) begin
      @(posedge tclk);
      n++;
    end
    chk("ack_wait", ack_out, lvl);
  endtask

  task automatic send(input logic [31:0] w);
    wait_ack(1'b0);
    @(posedge tclk);
    din = w;
    sb.push_back(w);
    @(posedge tclk);
    req_in = 1'b1;
    wait_ack(1'b1);
    @(posedge tclk);
    req_in = 1'b0;
    wait_ack(1'b0);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_r);
    #1;
  endtask

  initial begin
    bit done;
    int n;
    // Reset held with request already high.
    rst_n_r  = 1'b0;
    req_in   = 1'b1;
    din      = 32'h0000_00C3;
    dout_rdy = 1'b1;
    sb.push_back(32'h0000_00C3);
    step(4);
    rst_n_r = 1'b1;
    step(2);
    chk("post_rst_not_yet", dout_val, 1'b0);
    step(1);
    chk("post_rst_cap_val", dout_val, 1'b1);
    chk("post_rst_cap_dout", dout, 32'h0000_00C3);
    chk("post_rst_cap_ack", ack_out, 1'b1);
    req_in = 1'b0;
    step(2);
    chk("release_ack_hold", ack_out, 1'b1);
    step(1);
    chk("release_ack_low", ack_out, 1'b0);

    // Single transfer with consumer ready.
    din = 32'h0000_1234;
    sb.push_back(32'h0000_1234);
    cnt_before = xfer_cnt;
    req_in = 1'b1;
    step(2);
    chk("single_not_yet", dout_val, 1'b0);
    step(1);
    chk("single_val", dout_val, 1'b1);
    chk("single_dout", dout, 32'h0000_1234);
    step(1);
    chk("single_cnt", xfer_cnt, cnt_before + 16'd1);
    chk("single_val_clr", dout_val, 1'b0);
    req_in = 1'b0;
    step(2);
    chk("single_ack_hold", ack_out, 1'b1);
    step(1);
    chk("single_ack_low", ack_out, 1'b0);

    // Back-pressure: second request must stall until the first word is taken.
    dout_rdy = 1'b0;
    send(32'h0000_A5A5);
    step(1);
    din = 32'h0000_5A5A;
    sb.push_back(32'h0000_5A5A);
    req_in = 1'b1;
    step(6);
    chk("bp_ack_stalled", ack_out, 1'b0);
    chk("bp_dout_held", dout, 32'h0000_A5A5);
    chk("bp_val_held", dout_val, 1'b1);
    dout_rdy = 1'b1;
    step(1);
    chk("bp_accept_clr", dout_val, 1'b0);
    step(1);
    chk("bp_cap_val", dout_val, 1'b1);
    chk("bp_cap_dout", dout, 32'h0000_5A5A);
    chk("bp_cap_ack", ack_out, 1'b1);
    req_in = 1'b0;
    wait_ack(1'b0);

    // Reset while in ACK with a word pending.
    step(1);
    dout_rdy = 1'b0;
    din = 32'h0000_0077;
    sb.push_back(32'h0000_0077);
    req_in = 1'b1;
    step(4);
    chk("mid_pre_ack", ack_out, 1'b1);
    chk("mid_pre_val", dout_val, 1'b1);
    rst_n_r = 1'b0;
    #1;
    chk("mid_async_ack", ack_out, 1'b0);
    chk("mid_async_val", dout_val, 1'b0);
    step(2);
    rst_n_r = 1'b1;
    step(2);
    chk("mid_recap_not_yet", dout_val, 1'b0);
    step(1);
    chk("mid_recap_val", dout_val, 1'b1);
    chk("mid_recap_dout", dout, 32'h0000_0077);
    dout_rdy = 1'b1;
    req_in = 1'b0;
    wait_ack(1'b0);
    step(2);
    chk("mid_cnt", xfer_cnt, 16'd1);

    // Asynchronous stream of random words with random consumer stalls.
    rst_n_r = 1'b0;
    step(2);
    rst_n_r = 1'b1;
    step(1);
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) send($urandom);
        done = 1'b1;
      end
      begin
        while (!done) begin
          dout_rdy = ($urandom_range(0, 3) != 0);
          step(1);
        end
        dout_rdy = 1'b1;
      end
    join
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      step(1);
      n++;
    end
    step(2);
    chk("async_drained", sb.size(), 0);
    chk("async_cnt", xfer_cnt, 16'd200);
    chk("async_cnt4", cnt4, 4'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
